spike_rate_encoder: RTL and testbench

- Converts a frame of NUM_INPUTS pixel intensities into deterministic rate-coded spike trains over TIME_STEPS cycles.
- Sits upstream of if_layer and drives its spike_in vector.
- Issues a one-cycle layer-clear pulse before each frame so downstream neuron state starts fresh.
- Signals frame completion so the host can load the next image.

---
 rtl/snn_pkg.sv | 19 +
 rtl/rate_accumulator.sv | 46 ++++
 rtl/spike_rate_encoder.sv | 101 ++++++++++
 tb/tb_spike_rate_encoder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared definitions for the spiking front-end: FSM encodings and a
// width helper usable in constant expressions.
package snn_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rate_accumulator.sv
// One rate-coding channel: latched pixel, phase accumulator and the
// registered carry-out spike.
module rate_accumulator
    import snn_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         run_i,
    input  logic         clear_i,
    input  logic [W-1:0] pix_i,
    output logic         spike_o
);

    logic [W-1:0] pix_q;
    logic [W-1:0] acc_q;
    logic         spike_q;
    logic [W:0]   sum;

    // Carry out of the wrapping accumulator is the spike.
    assign sum     = {1'b0, acc_q} + {1'b0, pix_q};
    assign spike_o = spike_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_q   <= '0;
            acc_q   <= '0;
            spike_q <= 1'b0;
        end else if (load_i) begin
            pix_q   <= pix_i;
            acc_q   <= '0;
            spike_q <= 1'b0;
        end else if (clear_i) begin
            acc_q   <= '0;
            spike_q <= 1'b0;
        end else if (run_i) begin
            acc_q   <= sum[W-1:0];
            spike_q <= sum[W];
        end else begin
            spike_q <= 1'b0;
        end
    end

endmodule

// File: rtl/spike_rate_encoder.sv
// Frame sequencer: accepts a pixel frame, pulses a layer clear, then
// streams TIME_STEPS rate-coded spike beats and signals completion.
module spike_rate_encoder
    import snn_pkg::*;
#(
    parameter int NUM_INPUTS  = 4,
    parameter int PIXEL_WIDTH = 8,
    parameter int TIME_STEPS  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            pixel_valid,
    input  logic [NUM_INPUTS*PIXEL_WIDTH-1:0] pixel_data,
    output logic                            pixel_ready,
    input  logic                            abort,
    output logic                            layer_clr,
    output logic [NUM_INPUTS-1:0]           spike_out,
    output logic                            spike_valid,
    output logic                            frame_done,
    output logic                            busy
);

    localparam int CW = clog2(TIME_STEPS + 1);
    localparam logic [CW-1:0] LAST = CW'(TIME_STEPS - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] step_q, step_d;
    logic          layer_clr_q, spike_valid_q, frame_done_q;
    logic          load, run, clr, done_d;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        load    = 1'b0;
        run     = 1'b0;
        clr     = 1'b0;
        done_d  = 1'b0;
        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            clr     = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // An abort seen in IDLE still blocks acceptance.
                    if (pixel_valid && !abort) begin
                        load    = 1'b1;
                        step_d  = '0;
                        state_d = ST_CLEAR;
                    end
                end
                ST_CLEAR: state_d = ST_RUN;
                ST_RUN: begin
                    run    = 1'b1;
                    step_d = step_q + 1'b1;
                    if (step_q == LAST) state_d = ST_DONE;
                end
                ST_DONE: begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            step_q        <= '0;
            layer_clr_q   <= 1'b0;
            spike_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            layer_clr_q   <= load;
            spike_valid_q <= run;
            frame_done_q  <= done_d;
        end
    end

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_ch
        rate_accumulator #(
            .W(PIXEL_WIDTH)
        ) u_acc (
            .clk    (clk),
            .rst    (rst),
            .load_i (load),
            .run_i  (run),
            .clear_i(clr),
            .pix_i  (pixel_data[g*PIXEL_WIDTH +: PIXEL_WIDTH]),
            .spike_o(spike_out[g])
        );
    end

    assign pixel_ready = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign layer_clr   = layer_clr_q;
    assign spike_valid = spike_valid_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Directed bench for spike_rate_encoder (4 channels, 8-bit pixels,
// 16 time steps).
module tb_spike_rate_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        pixel_valid;
    logic [31:0] pixel_data;
    logic        pixel_ready;
    logic        abort;
    logic        layer_clr;
    logic [3:0]  spike_out;
    logic        spike_valid;
    logic        frame_done;
    logic        busy;

    int n_chk = 0;
    int errs  = 0;

    int          beat;
    int          cnt   [4];
    int          first [4];
    logic [15:0] pat   [4];
    logic        fd_seen;
    int          cyc = 0;
    int          acc_last = -1;

    spike_rate_encoder #(
        .NUM_INPUTS (4),
        .PIXEL_WIDTH(8),
        .TIME_STEPS (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pixel_valid(pixel_valid),
        .pixel_data (pixel_data),
        .pixel_ready(pixel_ready),
        .abort      (abort),
        .layer_clr  (layer_clr),
        .spike_out  (spike_out),
        .spike_valid(spike_valid),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst && pixel_valid && pixel_ready && !abort) acc_last = cyc;
    end

    always @(negedge clk) begin
        if (layer_clr) begin
            beat = 0;
            for (int c = 0; c < 4; c++) begin
                cnt[c]   = 0;
                first[c] = -1;
                pat[c]   = '0;
            end
        end
        if (spike_valid) begin
            for (int c = 0; c < 4; c++) begin
                if (spike_out[c]) begin
                    cnt[c] = cnt[c] + 1;
                    if (first[c] < 0) first[c] = beat;
                    if (beat < 16) pat[c][beat] = 1'b1;
                end
            end
            beat = beat + 1;
        end
        if (frame_done) fd_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [31:0] d);
        int n;
        n = 0;
        while (!pixel_ready && n < 50) begin
            step();
            n++;
        end
        pixel_data  = d;
        pixel_valid = 1'b1;
        step();
        pixel_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!frame_done && n < 40) begin
            step();
            n++;
        end
        check(tag, {31'd0, frame_done}, 32'd1);
    endtask

    task automatic check_frame_a();
        check("a_cnt0", cnt[0], 0);
        check("a_cnt1", cnt[1], 4);
        check("a_cnt2", cnt[2], 8);
        check("a_cnt3", cnt[3], 15);
        check("a_pat0", {16'd0, pat[0]}, 32'h0000);
        check("a_pat1", {16'd0, pat[1]}, 32'h8888);
        check("a_pat2", {16'd0, pat[2]}, 32'hAAAA);
        check("a_pat3", {16'd0, pat[3]}, 32'hFFFE);
        check("a_beats", beat, 16);
    endtask

    localparam logic [31:0] FRAME_A = {8'd255, 8'd128, 8'd64, 8'd0};
    localparam logic [31:0] FRAME_B = {8'd16, 8'd200, 8'd96, 8'd32};

    initial begin
        int a1, n;
        rst         = 1'b1;
        pixel_valid = 1'b0;
        pixel_data  = '0;
        abort       = 1'b0;
        fd_seen     = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rst_ready", {31'd0, pixel_ready}, 1);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_sv", {31'd0, spike_valid}, 0);
        check("rst_spk", {28'd0, spike_out}, 0);
        check("rst_clr", {31'd0, layer_clr}, 0);
        check("rst_fd", {31'd0, frame_done}, 0);
        repeat (2) step();
        @(negedge clk) rst = 1'b1;

        // Frame A with cycle-exact handshake checks
        start_frame(FRAME_A);
        check("e0_clr", {31'd0, layer_clr}, 1);
        check("e0_busy", {31'd0, busy}, 1);
        check("e0_ready", {31'd0, pixel_ready}, 0);
        step();
        check("e1_clr", {31'd0, layer_clr}, 0);
        check("e1_sv", {31'd0, spike_valid}, 0);
        for (int b = 0; b < 16; b++) begin
            step();
            check($sformatf("sv_b%0d", b), {31'd0, spike_valid}, 1);
        end
        step();
        check("end_sv", {31'd0, spike_valid}, 0);
        check("end_fd", {31'd0, frame_done}, 1);
        check("end_ready", {31'd0, pixel_ready}, 1);
        check("end_spk", {28'd0, spike_out}, 0);
        step();
        check("end_fd_lo", {31'd0, frame_done}, 0);
        check_frame_a();

        // pixel_valid toggled with new data while running
        start_frame(FRAME_B);
        repeat (4) step();
        for (int k = 0; k < 6; k++) begin
            pixel_data  = 32'hFFFF_FFFF;
            pixel_valid = ~pixel_valid;
            step();
        end
        pixel_valid = 1'b0;
        wait_done("b_done");
        check("b_cnt0", cnt[0], 2);
        check("b_cnt1", cnt[1], 6);
        check("b_cnt2", cnt[2], 12);
        check("b_cnt3", cnt[3], 1);

        // Back-to-back with pixel_valid held
        pixel_data  = {4{8'd128}};
        pixel_valid = 1'b1;
        step();
        a1 = acc_last;
        pixel_data = {4{8'd64}};
        n = 0;
        while (acc_last == a1 && n < 30) begin
            step();
            n++;
        end
        pixel_valid = 1'b0;
        check("b2b_gap", acc_last - a1, 19);
        wait_done("b2b_done");
        check("b2b_first0", first[0], 3);
        check("b2b_first3", first[3], 3);
        check("b2b_cnt0", cnt[0], 4);

        // Abort on beat 5
        start_frame({4{8'd255}});
        repeat (7) step();
        check("ab_pre_sv", {31'd0, spike_valid}, 1);
        fd_seen = 1'b0;
        abort   = 1'b1;
        step();
        abort = 1'b0;
        check("ab_sv", {31'd0, spike_valid}, 0);
        check("ab_spk", {28'd0, spike_out}, 0);
        check("ab_ready", {31'd0, pixel_ready}, 1);
        check("ab_busy", {31'd0, busy}, 0);
        check("ab_clr", {31'd0, layer_clr}, 0);
        repeat (20) step();
        check("ab_no_fd", {31'd0, fd_seen}, 0);

        // Abort in IDLE beats pixel_valid
        abort       = 1'b1;
        pixel_valid = 1'b1;
        pixel_data  = FRAME_A;
        step();
        abort       = 1'b0;
        pixel_valid = 1'b0;
        check("ab_idle_busy", {31'd0, busy}, 0);
        check("ab_idle_clr", {31'd0, layer_clr}, 0);

        start_frame(FRAME_A);
        wait_done("ab_fresh_done");
        check_frame_a();

        // Async reset on beat 8
        start_frame({4{8'd64}});
        repeat (10) step();
        check("rr_pre_sv", {31'd0, spike_valid}, 1);
        #2 rst = 1'b0;
        #1;
        check("rr_sv", {31'd0, spike_valid}, 0);
        check("rr_spk", {28'd0, spike_out}, 0);
        check("rr_ready", {31'd0, pixel_ready}, 1);
        check("rr_busy", {31'd0, busy}, 0);
        check("rr_fd", {31'd0, frame_done}, 0);
        repeat (2) step();
        check("rr_hold_ready", {31'd0, pixel_ready}, 1);
        @(negedge clk) rst = 1'b1;
        start_frame({4{8'd255}});
        wait_done("rr_done");
        for (int c = 0; c < 4; c++) begin
            check($sformatf("rr_cnt%0d", c), cnt[c], 15);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, errs);
        $finish;
    end

endmodule
